// File: rtl/cordic_seq_pkg.sv
// Shared constants for the CORDIC request sequencer: Q16 data width,
// default queue depth and watchdog limit, FSM state encoding and the
// queued request layout {mode, theta}.
package cordic_seq_pkg;

  localparam int DATA_W                 = 32;
  localparam int REQ_W                  = DATA_W + 1;
  localparam int DEFAULT_FIFO_DEPTH     = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Queue entry: mode sits in the MSB, theta below it.
  function automatic logic [REQ_W-1:0] pack_req(input logic mode,
                                                input logic [DATA_W-1:0] theta);
    return {mode, theta};
  endfunction

endpackage

// File: rtl/cordic_req_fifo.sv
// Request queue for the CORDIC sequencer. Stores {mode, theta} entries,
// DEPTH must be a power of two (2..16) so the pointers wrap naturally.
// pop_data always shows the head entry; push on a full queue and pop on
// an empty queue are ignored.
module cordic_req_fifo
  import cordic_seq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [REQ_W-1:0]         push_data,
  input  logic                     pop,
  output logic [REQ_W-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cordic_req_fifo: DEPTH must be a power of two in 2..16");
  end

  logic [REQ_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cordic_req_sequencer.sv
// CORDIC request sequencer: queues {mode, theta} requests, issues them one
// at a time to a CORDIC engine with a single-cycle cor_start, waits for
// cor_done and presents the result on a valid/ready response port.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised, holds its payload stable until that
// edge (req_* from the requester, rsp_* from this block).
//
// Optional macro CORDIC_SEQ_TIMEOUT_EN adds an engine watchdog: after
// TIMEOUT_CYCLES cycles in BUSY without cor_done the block answers with
// rsp_data=0, rsp_err=1. Without it rsp_err is tied low and BUSY waits
// for cor_done indefinitely.
module cordic_req_sequencer
  import cordic_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_mode,
  input  logic [31:0]                 req_theta,
  output logic                        cor_start,
  output logic                        cor_mode,
  output logic [31:0]                 cor_theta,
  input  logic [31:0]                 cor_result,
  input  logic                        cor_done,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [31:0]                 rsp_data,
  output logic                        rsp_err,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("cordic_req_sequencer: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [REQ_W-1:0] fifo_head;
  logic             capture_done;
  logic             capture_timeout;
  logic             wd_expired;

  cordic_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_valid),
    .push_data (pack_req(req_mode, req_theta)),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign req_ready = !fifo_full;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign cor_start = (state == ST_ISSUE);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE) || !fifo_empty;

`ifdef CORDIC_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  assign wd_expired = (state == ST_BUSY) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: cleared while issuing, counts each BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      wd_cnt <= '0;
    end else if (state == ST_BUSY && !wd_expired) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  // Next-state logic; cor_done is only looked at in BUSY and wins over
  // a watchdog expiry in the same cycle.
  always_comb begin
    next_state      = state;
    capture_done    = 1'b0;
    capture_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        next_state = ST_BUSY;
      end
      ST_BUSY: begin
        if (cor_done) begin
          next_state   = ST_RESP;
          capture_done = 1'b1;
        end else if (wd_expired) begin
          next_state      = ST_RESP;
          capture_timeout = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Engine operand registers: loaded on pop, held until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cor_mode  <= 1'b0;
      cor_theta <= '0;
    end else if (fifo_pop) begin
      cor_mode  <= fifo_head[REQ_W-1];
      cor_theta <= fifo_head[DATA_W-1:0];
    end
  end

  // Response data: captured on completion or forced to zero on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
    end else if (capture_done) begin
      rsp_data <= cor_result;
    end else if (capture_timeout) begin
      rsp_data <= '0;
    end
  end

`ifdef CORDIC_SEQ_TIMEOUT_EN
  // Error flag: set only when the watchdog produced the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (capture_done) begin
      rsp_err <= 1'b0;
    end else if (capture_timeout) begin
      rsp_err <= 1'b1;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_req_sequencer.sv
// Bench for cordic_req_sequencer: table of angle requests checked through a
// scoreboard against a behavioural CORDIC engine, plus hand-written burst,
// back-pressure, reset, spurious-done and (with CORDIC_SEQ_TIMEOUT_EN)
// watchdog sequences. Inputs change 1ns after posedge; outputs are sampled
// at negedge.
module tb_cordic_req_sequencer;

  localparam int FIFO_DEPTH = 4;
`ifdef CORDIC_SEQ_TIMEOUT_EN
  localparam int TIMEOUT = 8;
`else
  localparam int TIMEOUT = 64;
`endif
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_mode;
  logic [31:0]      req_theta;
  logic             cor_start;
  logic             cor_mode;
  logic [31:0]      cor_theta;
  logic [31:0]      cor_result;
  logic             cor_done;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;

  cordic_req_sequencer #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_theta  (req_theta),
    .cor_start  (cor_start),
    .cor_mode   (cor_mode),
    .cor_theta  (cor_theta),
    .cor_result (cor_result),
    .cor_done   (cor_done),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  typedef struct {
    logic        mode;
    logic [31:0] theta;
    logic [31:0] exp_data;
  } vec_t;

  logic [32:0] exp_q[$];      // {err, data}
  logic [32:0] req_exp;
  int          n_vec;
  int          n_err;
  int          cycle;
  int          start_cnt;
  int          push_cyc;
  int          start_cyc;
  int          rsp_cyc;
  logic        last_push;
  logic        rsp_seen;

  // engine model state
  logic        eng_pending;
  logic        eng_stall;
  logic        spur_done;
  int          eng_lat;
  int          eng_cnt;
  logic        eng_mode;
  logic [31:0] eng_theta;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [31:0] model(input logic mode, input logic [31:0] theta);
    real deg;
    real rad;
    real r;
    int  v;
    deg = $itor($signed(theta)) / 65536.0;
    rad = deg * 3.14159265358979 / 180.0;
    r   = mode ? $sin(rad) : $cos(rad);
    r   = r * 65536.0;
    v   = $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
    return v;
  endfunction

  // One clock cycle: sample at negedge, then step the engine after posedge.
  task automatic tick();
    logic [32:0] e;
    int          diff;
    last_push = 1'b0;
    @(negedge clk);
    if (cor_start) begin
      check("start_while_busy", {63'd0, eng_pending}, 64'd0);
      start_cnt++;
      start_cyc   = cycle;
      eng_pending = 1'b1;
      eng_cnt     = eng_lat;
      eng_mode    = cor_mode;
      eng_theta   = cor_theta;
    end else if (eng_pending) begin
      check("cor_hold", {31'd0, cor_mode, cor_theta}, {31'd0, eng_mode, eng_theta});
    end
    if (req_valid && req_ready) begin
      last_push = 1'b1;
      push_cyc  = cycle;
      exp_q.push_back(req_exp);
    end
    if (rsp_valid && !rsp_seen) begin
      rsp_seen = 1'b1;
      rsp_cyc  = cycle;
    end
    if (rsp_valid && rsp_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rsp: got data %h err %b, required no response", rsp_data, rsp_err);
      end else begin
        e    = exp_q.pop_front();
        diff = int'($signed(rsp_data)) - int'($signed(e[31:0]));
        if (rsp_err !== e[32] || diff > 2 || diff < -2) begin
          n_err++;
          $display("FAIL rsp: got data %h err %b, required data %h (+/-2) err %b",
                   rsp_data, rsp_err, e[31:0], e[32]);
        end
      end
    end
    @(posedge clk);
    #1;
    cor_done = 1'b0;
    if (spur_done) begin
      cor_done   = 1'b1;
      cor_result = 32'h1234_5678;
      spur_done  = 1'b0;
    end else if (eng_pending && !eng_stall) begin
      if (eng_cnt <= 1) begin
        cor_done    = 1'b1;
        cor_result  = model(eng_mode, eng_theta);
        eng_pending = 1'b0;
      end else begin
        eng_cnt--;
      end
    end
    cycle++;
  endtask

  task automatic send(input logic mode, input logic [31:0] theta, input logic [32:0] exp);
    req_valid = 1'b1;
    req_mode  = mode;
    req_theta = theta;
    req_exp   = exp;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (last_push) break;
    end
    check("push_accepted", {63'd0, last_push}, 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int k = 0; k < bound; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_rsp(input int bound);
    for (int k = 0; k < bound; k++) begin
      if (rsp_seen) break;
      tick();
    end
    check("rsp_arrived", {63'd0, rsp_seen}, 64'd1);
  endtask

  // ---------------- global time bound ----------------
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "time limit");
  end

  // ---------------- main sequence ----------------
  vec_t        vecs[8];
  vec_t        burst[5];
  logic [31:0] hold_data;
  int          sc;

  initial begin
    n_vec = 0; n_err = 0; cycle = 0; start_cnt = 0;
    push_cyc = 0; start_cyc = 0; rsp_cyc = 0;
    last_push = 0; rsp_seen = 0;
    eng_pending = 0; eng_stall = 0; spur_done = 0; eng_lat = 3; eng_cnt = 0;
    eng_mode = 0; eng_theta = '0;
    rst_n = 0; req_valid = 0; req_mode = 0; req_theta = '0; req_exp = '0;
    cor_result = '0; cor_done = 0; rsp_ready = 1;

    vecs[0] = '{1'b1, 32'h001E_0000, 32'h0000_8000};  // sin 30
    vecs[1] = '{1'b0, 32'h0000_0000, 32'h0001_0000};  // cos 0
    vecs[2] = '{1'b1, 32'h005A_0000, 32'h0001_0000};  // sin 90
    vecs[3] = '{1'b0, 32'h003C_0000, 32'h0000_8000};  // cos 60
    vecs[4] = '{1'b1, 32'hFFA6_0000, 32'hFFFF_0000};  // sin -90
    vecs[5] = '{1'b0, 32'h00B4_0000, 32'hFFFF_0000};  // cos 180
    vecs[6] = '{1'b1, 32'h0000_0000, 32'h0000_0000};  // sin 0
    vecs[7] = '{1'b1, 32'hFFE2_0000, 32'hFFFF_8000};  // sin -30

    burst[0] = '{1'b0, 32'h0000_0000, 32'h0001_0000};  // cos 0
    burst[1] = '{1'b0, 32'h005A_0000, 32'h0000_0000};  // cos 90
    burst[2] = '{1'b0, 32'h00B4_0000, 32'hFFFF_0000};  // cos 180
    burst[3] = '{1'b0, 32'h010E_0000, 32'h0000_0000};  // cos 270
    burst[4] = '{1'b1, 32'h001E_0000, 32'h0000_8000};  // sin 30

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_cor_start",  {63'd0, cor_start}, 64'd0);
    check("rst_cor_mode",   {63'd0, cor_mode}, 64'd0);
    check("rst_cor_theta",  64'(cor_theta), 64'd0);
    check("rst_rsp_valid",  {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_data",   64'(rsp_data), 64'd0);
    check("rst_rsp_err",    {63'd0, rsp_err}, 64'd0);
    check("rst_busy",       {63'd0, busy}, 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    rst_n = 1'b1;
    check("req_ready_after_rst", {63'd0, req_ready}, 64'd1);
    tick(); tick();

    // table: single requests, latency and result
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].mode, vecs[i].theta, {1'b0, vecs[i].exp_data});
      wait_drain(100);
      check("start_latency", 64'(start_cyc - push_cyc), 64'd2);
      check("idle_after_rsp", {63'd0, busy}, 64'd0);
    end

    // burst into a stalled engine
    eng_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_mode  = burst[i].mode;
      req_theta = burst[i].theta;
      req_exp   = {1'b0, burst[i].exp_data};
      tick();
      check("burst_accept", {63'd0, last_push}, 64'd1);
    end
    req_valid = 1'b0;
    check("burst_count", 64'(fifo_count), 64'd4);
    check("burst_ready", {63'd0, req_ready}, 64'd0);
    req_valid = 1'b1;
    req_theta = 32'h0099_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_refuse", {63'd0, last_push}, 64'd0);
    end
    req_valid = 1'b0;
    eng_stall = 1'b0;
    wait_drain(300);

    // response back-pressure while the queue keeps filling
    rsp_ready = 1'b0;
    rsp_seen  = 1'b0;
    send(1'b1, 32'h001E_0000, {1'b0, 32'h0000_8000});
    wait_rsp(50);
    hold_data = rsp_data;
    sc        = start_cnt;
    for (int i = 0; i < 10; i++) begin
      req_valid = (i < 2);
      req_mode  = 1'b0;
      req_theta = (i == 0) ? 32'h0000_0000 : 32'h00B4_0000;
      req_exp   = (i == 0) ? {1'b0, 32'h0001_0000} : {1'b0, 32'hFFFF_0000};
      tick();
      check("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("bp_rsp_data", 64'(rsp_data), 64'(hold_data));
    end
    req_valid = 1'b0;
    check("bp_no_restart", 64'(start_cnt - sc), 64'd0);
    check("bp_count", 64'(fifo_count), 64'd2);
    rsp_ready = 1'b1;
    wait_drain(200);

    // reset while BUSY with two entries queued
    eng_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_mode  = 1'b1;
      req_theta = 32'h0011_0000 + 32'(i);
      req_exp   = {1'b0, model(1'b1, req_theta)};
      tick();
    end
    req_valid = 1'b0;
    tick(); tick();
    check("pre_rst_count", 64'(fifo_count), 64'd2);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_cor_start",  {63'd0, cor_start}, 64'd0);
    check("arst_cor_mode",   {63'd0, cor_mode}, 64'd0);
    check("arst_cor_theta",  64'(cor_theta), 64'd0);
    check("arst_rsp_valid",  {63'd0, rsp_valid}, 64'd0);
    check("arst_rsp_data",   64'(rsp_data), 64'd0);
    check("arst_rsp_err",    {63'd0, rsp_err}, 64'd0);
    check("arst_busy",       {63'd0, busy}, 64'd0);
    check("arst_fifo_count", 64'(fifo_count), 64'd0);
    exp_q.delete();
    eng_pending = 1'b0;
    eng_stall   = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("req_ready_after_arst", {63'd0, req_ready}, 64'd1);
    sc = start_cnt;
    for (int i = 0; i < 20; i++) tick();
    check("arst_no_start", 64'(start_cnt - sc), 64'd0);
    check("arst_idle", {63'd0, busy}, 64'd0);

    // spurious cor_done while IDLE
    rsp_seen  = 1'b0;
    sc        = start_cnt;
    spur_done = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("spur_no_rsp", {63'd0, rsp_seen}, 64'd0);
    check("spur_idle", {63'd0, busy}, 64'd0);
    check("spur_no_start", 64'(start_cnt - sc), 64'd0);

`ifdef CORDIC_SEQ_TIMEOUT_EN
    // engine never finishes: watchdog answers after TIMEOUT cycles of BUSY
    eng_stall = 1'b1;
    rsp_seen  = 1'b0;
    send(1'b1, 32'h002D_0000, {1'b1, 32'h0000_0000});
    wait_rsp(50);
    check("timeout_latency", 64'(rsp_cyc - (start_cyc + 1)), 64'(TIMEOUT));
    wait_drain(50);
    eng_pending = 1'b0;
    eng_stall   = 1'b0;
    tick();

    // done on the last watchdog cycle wins
    eng_lat  = TIMEOUT;
    rsp_seen = 1'b0;
    send(1'b0, 32'h0000_0000, {1'b0, 32'h0001_0000});
    wait_rsp(50);
    check("done_at_limit_latency", 64'(rsp_cyc - (start_cyc + 1)), 64'(TIMEOUT));
    wait_drain(50);
    eng_lat = 3;
`endif

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
